// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter
//
// Arbitrates line refills from the icache demand-miss path and the next-line
// prefetcher onto the single upstream ifill port. At most one refill is
// outstanding at a time. Response beats are counted and forwarded, without
// registering, to the requester that owns the refill. A flush drains the
// in-flight refill without forwarding any more of its beats.
//
// Build option: define ICACHE_REFILL_PREFETCH_EN to enable the prefetch
// port. When it is undefined, the pf_req_* inputs are ignored and the pf_*
// outputs are tied to 0.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   flush_i                  icache flush
//   dem_req_*                demand refill request (valid/paddr/way)
//   pf_req_*                 prefetch refill request (valid/paddr/way)
//   dem_gnt_o, pf_gnt_o      accept pulses, issued in the upstream handshake cycle
//   mem_req_*                upstream request (valid/paddr/way/ready)
//   mem_resp_*               upstream beats (valid & ack qualify a beat)
//   dem/pf_resp_valid_o      beat forwarded to the owner
//   resp_beat_o, resp_data_o forwarded beat index and data (0 when not forwarding)
//   dem/pf_done_o            pulse on the owner's last beat
//   busy_o                   a refill is in progress
//   err_o                    sticky beat-order error, cleared by flush_i

module icache_refill_arbiter #(
    parameter int unsigned PADDR_WIDTH = 26,
    parameter int unsigned WAY_WIDTH   = 2,
    parameter int unsigned BEAT_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH  = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,

    input  logic                   dem_req_valid_i,
    input  logic [PADDR_WIDTH-1:0] dem_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]   dem_req_way_i,
    input  logic                   pf_req_valid_i,
    input  logic [PADDR_WIDTH-1:0] pf_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]   pf_req_way_i,
    output logic                   dem_gnt_o,
    output logic                   pf_gnt_o,

    output logic                   mem_req_valid_o,
    output logic [PADDR_WIDTH-1:0] mem_req_paddr_o,
    output logic [WAY_WIDTH-1:0]   mem_req_way_o,
    input  logic                   mem_req_ready_i,

    input  logic                   mem_resp_valid_i,
    input  logic                   mem_resp_ack_i,
    input  logic [BEAT_WIDTH-1:0]  mem_resp_beat_i,
    input  logic [DATA_WIDTH-1:0]  mem_resp_data_i,

    output logic                   dem_resp_valid_o,
    output logic                   pf_resp_valid_o,
    output logic [BEAT_WIDTH-1:0]  resp_beat_o,
    output logic [DATA_WIDTH-1:0]  resp_data_o,
    output logic                   dem_done_o,
    output logic                   pf_done_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam logic [BEAT_WIDTH-1:0] LastBeat = '1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } state_e;

    state_e                  state_q, state_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [WAY_WIDTH-1:0]    way_q, way_d;
    logic [BEAT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    flush_seen_q, flush_seen_d;
    logic                    err_q, err_d;

    // Owner bookkeeping: owner_pf is set when the prefetcher owns the refill,
    // merged when a same-line prefetch rode along with a demand refill.
    logic                    owner_pf, merged;
    logic                    owner_pf_d, merged_d;
    logic                    pf_vld;

    logic                    beat_vld;
    logic                    last_beat;
    logic                    gnt;
    logic                    fwd;
    logic                    done;

    assign beat_vld  = mem_resp_valid_i & mem_resp_ack_i;
    assign last_beat = (cnt_q == LastBeat);

`ifdef ICACHE_REFILL_PREFETCH_EN
    logic owner_pf_q, merged_q;

    assign pf_vld   = pf_req_valid_i;
    assign owner_pf = owner_pf_q;
    assign merged   = merged_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_pf_q <= 1'b0;
            merged_q   <= 1'b0;
        end else begin
            owner_pf_q <= owner_pf_d;
            merged_q   <= merged_d;
        end
    end
`else
    assign pf_vld   = 1'b0;
    assign owner_pf = 1'b0;
    assign merged   = 1'b0;

    logic unused_pf;
    assign unused_pf = ^{pf_req_valid_i, pf_req_paddr_i, pf_req_way_i, owner_pf_d, merged_d};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            paddr_q      <= '0;
            way_q        <= '0;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            way_q        <= way_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        paddr_d         = paddr_q;
        way_d           = way_q;
        cnt_d           = cnt_q;
        flush_seen_d    = flush_seen_q;
        err_d           = err_q;
        owner_pf_d      = owner_pf;
        merged_d        = merged;
        mem_req_valid_o = 1'b0;
        gnt             = 1'b0;
        fwd             = 1'b0;
        done            = 1'b0;

        unique case (state_q)
            StIdle: begin
                // No refill is outstanding, so any beat here is stray.
                if (beat_vld) begin
                    err_d = 1'b1;
                end
                flush_seen_d = 1'b0;
                if (!flush_i) begin
                    if (dem_req_valid_i) begin
                        paddr_d    = dem_req_paddr_i;
                        way_d      = dem_req_way_i;
                        owner_pf_d = 1'b0;
                        merged_d   = pf_vld && (pf_req_paddr_i == dem_req_paddr_i);
                        state_d    = StReq;
                    end else if (pf_vld) begin
                        paddr_d    = pf_req_paddr_i;
                        way_d      = pf_req_way_i;
                        owner_pf_d = 1'b1;
                        merged_d   = 1'b0;
                        state_d    = StReq;
                    end
                end
            end

            StReq: begin
                mem_req_valid_o = 1'b1;
                if (beat_vld) begin
                    err_d = 1'b1;
                end
                if (flush_i) begin
                    flush_seen_d = 1'b1;
                end
                // The upstream request cannot be retracted. Once accepted, a
                // flushed refill still returns beats, and those are drained.
                if (mem_req_ready_i) begin
                    cnt_d        = '0;
                    flush_seen_d = 1'b0;
                    if (flush_i || flush_seen_q) begin
                        state_d = StDrain;
                    end else begin
                        gnt     = 1'b1;
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                if (flush_i) begin
                    // The flush-cycle beat is consumed but not forwarded.
                    if (beat_vld) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = last_beat ? StIdle : StDrain;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (beat_vld) begin
                    fwd   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (mem_resp_beat_i != cnt_q) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            StDrain: begin
                if (beat_vld) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush_i) begin
            err_d = 1'b0;
        end
    end

    assign mem_req_paddr_o  = paddr_q;
    assign mem_req_way_o    = way_q;
    assign busy_o           = (state_q != StIdle);
    assign err_o            = err_q;

    assign dem_gnt_o        = gnt & ~owner_pf;
    assign dem_resp_valid_o = fwd & ~owner_pf;
    assign dem_done_o       = done & ~owner_pf;

`ifdef ICACHE_REFILL_PREFETCH_EN
    assign pf_gnt_o         = gnt & (owner_pf | merged);
    assign pf_resp_valid_o  = fwd & owner_pf;
    assign pf_done_o        = done & owner_pf;
`else
    assign pf_gnt_o         = 1'b0;
    assign pf_resp_valid_o  = 1'b0;
    assign pf_done_o        = 1'b0;
`endif

    assign resp_beat_o      = fwd ? mem_resp_beat_i : '0;
    assign resp_data_o      = fwd ? mem_resp_data_i : '0;

endmodule
